// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: sequencing controller for the E-stage multiply/divide unit.
// Captures a 64-bit MD result at the start edge and holds busy for a fixed
// latency. It then commits the result to the architectural HI/LO registers.
// mthi/mtlo take effect in a single cycle.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | no operation in flight; accepts start
// ST_RUN   | counter > 0; result pending, start ignored
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_valid;

    logic        w_idle;
    logic        w_launch;
    logic        w_is_div;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_commit;
    logic [3:0]  w_load;

    // Datapath intermediates
    logic [63:0] w_a_sx;
    logic [63:0] w_b_sx;
    logic [63:0] w_smul;
    logic [63:0] w_umul;
    logic        w_signed_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_num;
    logic [31:0] w_den;
    logic [31:0] w_den_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_valid;

    assign busy = (r_state == ST_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Signed product is taken on sign-extended 64-bit operands; the low 64
    // bits of that product equal the true two's-complement result.
    assign w_a_sx = {{32{A[31]}}, A};
    assign w_b_sx = {{32{B[31]}}, B};
    assign w_smul = w_a_sx * w_b_sx;
    assign w_umul = {32'd0, A} * {32'd0, B};

    // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly
    // to 0x80000000 instead of relying on signed-divide overflow behaviour.
    assign w_signed_div = (md_op == OP_DIV);
    assign w_a_neg      = w_signed_div & A[31];
    assign w_b_neg      = w_signed_div & B[31];
    assign w_num        = w_a_neg ? (~A + 32'd1) : A;
    assign w_den        = w_b_neg ? (~B + 32'd1) : B;
    assign w_den_safe   = (w_den == 32'd0) ? 32'd1 : w_den;
    assign w_q_mag      = w_num / w_den_safe;
    assign w_r_mag      = w_num % w_den_safe;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem        = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    // Result selection for the launching op; a zero divisor marks the result
    // invalid so HI/LO are left untouched at commit.
    always_comb begin
        w_res_hi    = 32'd0;
        w_res_lo    = 32'd0;
        w_res_valid = 1'b1;
        case (md_op)
            OP_MULT: begin
                w_res_hi = w_smul[63:32];
                w_res_lo = w_smul[31:0];
            end
            OP_MULTU: begin
                w_res_hi = w_umul[63:32];
                w_res_lo = w_umul[31:0];
            end
            OP_DIV, OP_DIVU: begin
                w_res_hi    = w_rem;
                w_res_lo    = w_quot;
                w_res_valid = (B != 32'd0);
            end
            default: begin
                w_res_valid = 1'b0;
            end
        endcase
    end

    // Next-state and control decode; start is only honoured in IDLE.
    always_comb begin
        w_next_state = r_state;
        w_idle       = (r_state == ST_IDLE);
        w_is_div     = (md_op == OP_DIV) || (md_op == OP_DIVU);
        w_launch     = 1'b0;
        w_mthi       = 1'b0;
        w_mtlo       = 1'b0;
        w_commit     = 1'b0;
        w_load       = w_is_div ? DIV_LOAD : MULT_LOAD;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_launch = (md_op == OP_MULT) || (md_op == OP_MULTU) || w_is_div;
                    w_mthi   = (md_op == OP_MTHI);
                    w_mtlo   = (md_op == OP_MTLO);
                end
                if (w_launch) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_count == 4'd1) begin
                    w_commit     = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latency down-counter: loaded at launch, terminal count 1 ends RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 4'd0;
        end else if (w_launch) begin
            r_count <= w_load;
        end else if (r_state == ST_RUN) begin
            r_count <= r_count - 4'd1;
        end
    end

    // Pending result captured at launch; operands are not looked at again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_hi    <= 32'd0;
            r_pend_lo    <= 32'd0;
            r_pend_valid <= 1'b0;
        end else if (w_launch) begin
            r_pend_hi    <= w_res_hi;
            r_pend_lo    <= w_res_lo;
            r_pend_valid <= w_res_valid;
        end
    end

    // Architectural HI: commit of a valid pending result, or mthi.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
        end else if (w_commit && r_pend_valid) begin
            r_hi <= r_pend_hi;
        end else if (w_mthi) begin
            r_hi <= A;
        end
    end

    // Architectural LO: commit of a valid pending result, or mtlo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lo <= 32'd0;
        end else if (w_commit && r_pend_valid) begin
            r_lo <= r_pend_lo;
        end else if (w_mtlo) begin
            r_lo <= A;
        end
    end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Sequencing controller for the multiply/divide resource in the E stage of the pipelined MIPS32 core.
- Accepts one MD operation per start pulse, counts out a fixed multi-cycle latency, then commits the result to the HI/LO registers.
- Drives `busy`; the hazard unit combines `busy|start` with the D-stage decode to stall MD instructions and mfhi/mflo.
- Also services the single-cycle writes mthi/mtlo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (range 1..15)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  launch pulse from E stage; qualifies md_op
- md_op  in  3  0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo, 7=reserved (no-op)
- A  in  32  rs operand (forwarded value)
- B  in  32  rt operand (forwarded value)
- busy  out  1  operation in flight
- hi  out  32  architectural HI register
- lo  out  32  architectural LO register

Behaviour:
- Reset (async, active-high), asserted at any time including mid-operation:
  - busy=0, hi=0, lo=0, counter=0, state=IDLE.
  - Any pending result is discarded; nothing is committed after reset releases.
- FSM states:
  - IDLE: no operation in flight.
  - RUN: counter > 0.
- In IDLE at a rising edge with start=1:
  - md_op 1..4:
    - Latch the computed 64-bit result into internal pending_hi/pending_lo.
    - Load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
    - Go to RUN; busy=1 from the next cycle.
  - md_op 5 (mthi): hi<=A this edge; stay IDLE; busy stays 0.
  - md_op 6 (mtlo): lo<=A this edge; stay IDLE; busy stays 0.
  - md_op 0 or 7: no state change.
- Timing (start sampled at edge t0):
  - busy is high during cycles t0+1 .. t0+N.
  - At the edge ending cycle t0+N, hi/lo<=pending values, busy<=0, state<=IDLE.
  - New hi/lo are visible from cycle t0+N+1, the same cycle busy reads 0.
- RUN decrements the counter each edge. On the edge where counter==1, commit and return to IDLE.
- start while busy=1 (any md_op, including mthi/mtlo): ignored. The in-flight operation completes unchanged. The hazard unit guarantees no start while busy; this rule is defensive.
- Operand semantics:
  - Operands are captured only at the start edge; A/B changes during RUN have no effect.
  - mult: signed 32x32 → {hi,lo} = 64-bit product.
  - multu: unsigned 32x32 → {hi,lo} = 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div with A=0x80000000, B=0xFFFFFFFF: lo=0x80000000, hi=0x00000000 (no trap).
- Divide by zero (B==0, div or divu):
  - Full DIV_CYCLES busy period still runs.
  - hi/lo are left unchanged at commit.
- Outputs hi, lo, busy are registered; no combinational path from inputs to outputs.
- Back-to-back operations:
  - A start at edge t0+N+1 is accepted; a start at edge t0+N is not (busy was still 1).
  - mthi at edge t0+N+1 overwrites the just-committed hi.

Test Plan:
1. Reset → start=1, md_op=1, A=0xFFFFFFFE (−2), B=3 → busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0 in the same cycle.
2. md_op=2 (multu), A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
3. md_op=3 (div), A=0xFFFFFFF9 (−7), B=2 → busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Repeat with A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
4. Preload via mthi A=0x1234, mtlo A=0x5678 (busy stays 0, values visible next cycle); then divu with B=0 → 10 busy cycles, hi=0x1234, lo=0x5678 unchanged.
5. Start mult with A=3, B=4; on the 2nd busy cycle pulse start with md_op=6, A=0xDEAD and change A/B → ignored; commit gives hi=0, lo=12 at the 5-cycle mark.
6. Start div A=100, B=7; assert reset asynchronously mid-cycle during busy cycle 4 → busy, hi, lo drop to 0 without waiting for a clock edge. After release, no commit occurs (hi=lo=0 for 15+ cycles); a new mult A=2, B=5 then yields lo=10.
